// File: rtl/hilo_pkg.sv
// Shared encodings for the HI/LO controller: instruction ops, engine ops and FSM states.
package hilo_pkg;

  typedef enum logic [2:0] {
    OP_MULT  = 3'd0,
    OP_MULTU = 3'd1,
    OP_DIV   = 3'd2,
    OP_DIVU  = 3'd3,
    OP_MFHI  = 3'd4,
    OP_MFLO  = 3'd5,
    OP_MTHI  = 3'd6,
    OP_MTLO  = 3'd7
  } hl_op_e;

  typedef enum logic [1:0] {
    MD_MULT  = 2'b00,
    MD_MULTU = 2'b01,
    MD_DIV   = 2'b10,
    MD_DIVU  = 2'b11
  } md_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2
  } state_e;

  // The low two op bits of a multiply/divide instruction are already the engine code.
  function automatic logic [1:0] md_code(input logic [2:0] op);
    return op[1:0];
  endfunction

endpackage

// File: rtl/hilo_regs.sv
// Architectural HI/LO register pair: independent write enables and a gated read mux.
module hilo_regs
  import hilo_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        i_we_hi,
  input  logic        i_we_lo,
  input  logic [31:0] i_wdata_hi,
  input  logic [31:0] i_wdata_lo,
  input  logic        i_rd_en,
  input  logic        i_rd_hi,
  output logic [31:0] o_rdata
);

  logic [31:0] r_hi;
  logic [31:0] r_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_we_hi) r_hi <= i_wdata_hi;
      if (i_we_lo) r_lo <= i_wdata_lo;
    end
  end

  assign o_rdata = !i_rd_en ? '0 : (i_rd_hi ? r_hi : r_lo);

endmodule

// File: rtl/hilo_ctrl.sv
// EX-stage HI/LO owner: issues mult/div to the engine over req/ack/done,
// writes results back, serves MF/MT moves and interlocks while the engine is busy.
module hilo_ctrl
  import hilo_pkg::*;
#(
  parameter int WAIT_LIMIT = 64,
  parameter int CNT_W      = 7
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ex_valid,
  input  logic [2:0]  ex_op,
  input  logic        ex_flush,
  input  logic [31:0] ex_rs_val,
  input  logic [31:0] ex_rt_val,
  output logic        ex_stall,
  output logic [31:0] ex_rdata,
  output logic        md_req,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_ack,
  input  logic        md_done,
  input  logic [31:0] md_hi,
  input  logic [31:0] md_lo,
  output logic        md_err
);

  state_e      r_state;
  state_e      w_state_next;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0] r_a;
  logic [31:0] r_b;
  logic [1:0]  r_op;
  logic        r_err;

  logic        w_act;
  logic        w_is_md;
  logic        w_busy;
  logic        w_timeout;
  logic        w_set_err;
  logic        w_done_wr;
  logic        w_mt;
  logic        w_we_hi;
  logic        w_we_lo;
  logic [31:0] w_wdata_hi;
  logic [31:0] w_wdata_lo;
  logic        w_rd_en;

  assign w_act     = ex_valid & ~ex_flush;
  assign w_is_md   = w_act & ~ex_op[2];
  assign w_busy    = (r_state != IDLE);
  assign w_timeout = w_busy && (r_cnt == CNT_W'(WAIT_LIMIT - 1));

  assign ex_stall = w_act & w_busy;
  assign md_req   = (r_state == REQ);
  assign md_a     = r_a;
  assign md_b     = r_b;
  assign md_op    = r_op;
  assign md_err   = r_err;

  // A completing done beats a timeout landing on the same edge.
  always_comb begin
    w_state_next = r_state;
    w_set_err    = 1'b0;
    w_done_wr    = 1'b0;
    case (r_state)
      IDLE: if (w_is_md) w_state_next = REQ;
      REQ: begin
        if (w_timeout) begin
          w_state_next = IDLE;
          w_set_err    = 1'b1;
        end else if (md_ack) begin
          w_state_next = WAIT;
        end
      end
      WAIT: begin
        if (md_done) begin
          w_state_next = IDLE;
          w_done_wr    = 1'b1;
        end else if (w_timeout) begin
          w_state_next = IDLE;
          w_set_err    = 1'b1;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Moves only act in IDLE; while busy they are stalled instead.
  assign w_mt       = ~w_busy & w_act & ex_op[2] & ex_op[1];
  assign w_rd_en    = ~w_busy & w_act & ex_op[2] & ~ex_op[1];
  assign w_we_hi    = w_done_wr | (w_mt & ~ex_op[0]);
  assign w_we_lo    = w_done_wr | (w_mt & ex_op[0]);
  assign w_wdata_hi = w_done_wr ? md_hi : ex_rs_val;
  assign w_wdata_lo = w_done_wr ? md_lo : ex_rs_val;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_set_err) r_err <= 1'b1;
      if (!w_busy && w_is_md) begin
        r_a   <= ex_rs_val;
        r_b   <= ex_rt_val;
        r_op  <= md_code(ex_op);
        r_cnt <= '0;
      end else if (w_busy && (r_cnt != {CNT_W{1'b1}})) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  hilo_regs u_regs (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_we_hi    (w_we_hi),
    .i_we_lo    (w_we_lo),
    .i_wdata_hi (w_wdata_hi),
    .i_wdata_lo (w_wdata_lo),
    .i_rd_en    (w_rd_en),
    .i_rd_hi    (~ex_op[0]),
    .o_rdata    (ex_rdata)
  );

endmodule

// File: tb/tb_hilo_ctrl.sv
// Self-checking bench for hilo_ctrl: vector table, directed engine sequences, randomized run vs a transaction model.
module tb_hilo_ctrl;
  import hilo_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic        ex_flush;
  logic [31:0] ex_rs_val;
  logic [31:0] ex_rt_val;
  logic        ex_stall;
  logic [31:0] ex_rdata;
  logic        md_req;
  logic [1:0]  md_op;
  logic [31:0] md_a;
  logic [31:0] md_b;
  logic        md_ack;
  logic        md_done;
  logic [31:0] md_hi;
  logic [31:0] md_lo;
  logic        md_err;

  always #5 clk = ~clk;

  hilo_ctrl #(.WAIT_LIMIT(64), .CNT_W(7)) dut (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_op(ex_op), .ex_flush(ex_flush),
    .ex_rs_val(ex_rs_val), .ex_rt_val(ex_rt_val), .ex_stall(ex_stall), .ex_rdata(ex_rdata),
    .md_req(md_req), .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_ack(md_ack),
    .md_done(md_done), .md_hi(md_hi), .md_lo(md_lo), .md_err(md_err)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // What a real engine would return: {hi, lo}.
  function automatic logic [63:0] engine_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic [63:0] q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'b0, a} * {32'b0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = 64'(sa / sb);
        r = 64'(sa % sb);
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  typedef struct {
    logic        v;
    logic [2:0]  op;
    logic        fl;
    logic [31:0] rs;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t tbl[12];

  // Transaction-level reference state for the random phase.
  bit          pend;
  int          k, a_cyc, c_cyc;
  logic [31:0] m_hi, m_lo;
  bit          m_err;
  logic [1:0]  p_op;
  logic [31:0] p_a, p_b;
  logic [63:0] p_res;

  initial begin
    rst_n = 1'b0; ex_valid = 0; ex_op = OP_MULT; ex_flush = 0; ex_rs_val = 0; ex_rt_val = 0;
    md_ack = 0; md_done = 0; md_hi = 0; md_lo = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_req", md_req, 0);
    check("rst_err", md_err, 0);
    check("rst_stall", ex_stall, 0);
    check("rst_rdata", ex_rdata, 0);
    check("rst_md_a", md_a, 0);
    check("rst_md_b", md_b, 0);
    check("rst_md_op", md_op, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();

    // IDLE moves; HI/LO start at 0.
    tbl[0]  = '{1'b0, OP_MFHI, 1'b0, 32'h0,         32'h0};
    tbl[1]  = '{1'b1, OP_MFHI, 1'b0, 32'h0,         32'h0};
    tbl[2]  = '{1'b1, OP_MTLO, 1'b0, 32'h1234_5678, 32'h0};
    tbl[3]  = '{1'b1, OP_MFLO, 1'b0, 32'h0,         32'h1234_5678};
    tbl[4]  = '{1'b1, OP_MTHI, 1'b1, 32'hCAFE_F00D, 32'h0};
    tbl[5]  = '{1'b1, OP_MFHI, 1'b0, 32'h0,         32'h0};
    tbl[6]  = '{1'b1, OP_MTHI, 1'b0, 32'hA5A5_A5A5, 32'h0};
    tbl[7]  = '{1'b1, OP_MFHI, 1'b0, 32'h0,         32'hA5A5_A5A5};
    tbl[8]  = '{1'b1, OP_DIVU, 1'b1, 32'h0000_0009, 32'h0};
    tbl[9]  = '{1'b1, OP_MFLO, 1'b0, 32'h0,         32'h1234_5678};
    tbl[10] = '{1'b1, OP_MFHI, 1'b1, 32'h0,         32'h0};
    tbl[11] = '{1'b0, OP_MFLO, 1'b0, 32'h0,         32'h0};
    for (int i = 0; i < 12; i++) begin
      ex_valid = tbl[i].v; ex_op = tbl[i].op; ex_flush = tbl[i].fl;
      ex_rs_val = tbl[i].rs; ex_rt_val = 32'h3;
      @(negedge clk);
      $display("vec %0d: valid=%0d op=%0d flush=%0d rdata=0x%08h", i, tbl[i].v, tbl[i].op, tbl[i].fl, ex_rdata);
      check("vec_stall", ex_stall, 0);
      check("vec_req", md_req, 0);
      check("vec_rdata", ex_rdata, tbl[i].exp_rdata);
      tick();
    end
    ex_flush = 0;

    // MULT: ack after 2 cycles, done after 5.
    ex_valid = 1; ex_op = OP_MULT; ex_rs_val = 32'hFFFF_FFFE; ex_rt_val = 32'd3;
    @(negedge clk); check("mult_issue_stall", ex_stall, 0); tick();
    ex_valid = 0;
    for (int c = 1; c <= 6; c++) begin
      md_ack = (c == 2); md_done = (c == 5);
      md_hi = (c == 5) ? 32'hFFFF_FFFF : $urandom;
      md_lo = (c == 5) ? 32'hFFFF_FFFA : $urandom;
      @(negedge clk);
      check("mult_req", md_req, c <= 2);
      if (c == 1) begin
        check("mult_md_a", md_a, 32'hFFFF_FFFE);
        check("mult_md_b", md_b, 32'd3);
        check("mult_md_op", md_op, MD_MULT);
      end
      tick();
    end
    md_ack = 0; md_done = 0;
    ex_valid = 1; ex_op = OP_MFHI;
    @(negedge clk); check("mult_hi", ex_rdata, 32'hFFFF_FFFF); check("mult_hi_stall", ex_stall, 0); tick();
    ex_op = OP_MFLO;
    @(negedge clk); check("mult_lo", ex_rdata, 32'hFFFF_FFFA); tick();
    $display("seq mult: done");

    // DIV followed by an interlocked MFLO; done 32 cycles later.
    ex_op = OP_DIV; ex_rs_val = 32'd100; ex_rt_val = 32'd7;
    @(negedge clk); check("div_issue_stall", ex_stall, 0); tick();
    ex_op = OP_MFLO;
    for (int c = 1; c <= 33; c++) begin
      md_ack = (c == 1); md_done = (c == 32);
      md_hi = (c == 32) ? 32'd2 : $urandom;
      md_lo = (c == 32) ? 32'd14 : $urandom;
      @(negedge clk);
      check("div_stall", ex_stall, c <= 32);
      if (c == 33) check("div_mflo", ex_rdata, 32'd14);
      tick();
    end
    md_ack = 0; md_done = 0;
    $display("seq div: done");

    // MULTU with no done: timeout after 64 busy cycles.
    ex_op = OP_MULTU; ex_rs_val = $urandom; ex_rt_val = $urandom;
    @(negedge clk); check("to_issue_stall", ex_stall, 0); tick();
    ex_op = OP_MFHI;
    for (int c = 1; c <= 65; c++) begin
      md_ack = (c == 1); md_done = 0; md_hi = $urandom; md_lo = $urandom;
      @(negedge clk);
      check("to_stall", ex_stall, c <= 64);
      check("to_err", md_err, c == 65);
      check("to_req", md_req, c == 1);
      if (c == 65) check("to_mfhi", ex_rdata, 32'd2);
      tick();
    end
    md_ack = 0;
    ex_op = OP_MFLO;
    @(negedge clk); check("to_mflo", ex_rdata, 32'd14); check("to_mflo_stall", ex_stall, 0); tick();
    $display("seq timeout: done");

    // Reset while in WAIT; late done must be discarded.
    ex_op = OP_MULT; ex_rs_val = 32'd5; ex_rt_val = 32'd6;
    tick();
    ex_valid = 0; md_ack = 1;
    @(negedge clk); check("rw_req", md_req, 1); tick();
    md_ack = 0;
    tick();
    ex_valid = 1; ex_op = OP_MFHI;
    #1; check("rw_pre_stall", ex_stall, 1);
    rst_n = 1'b0;
    #1;
    check("rw_req_async", md_req, 0);
    check("rw_stall_async", ex_stall, 0);
    check("rw_err_clr", md_err, 0);
    check("rw_md_a", md_a, 0);
    check("rw_rdata", ex_rdata, 0);
    @(negedge clk) rst_n = 1'b1;
    tick();
    ex_valid = 0; md_done = 1; md_hi = 32'hDEAD_BEEF; md_lo = 32'hFEED_FACE;
    tick();
    md_done = 0; ex_valid = 1; ex_op = OP_MFHI;
    @(negedge clk); check("rw_hi", ex_rdata, 0); tick();
    ex_op = OP_MFLO;
    @(negedge clk); check("rw_lo", ex_rdata, 0); tick();
    ex_valid = 0;
    $display("seq reset-in-wait: done");

    // Randomized run against the transaction model.
    pend = 0; k = 0; a_cyc = 0; c_cyc = 0; m_hi = 0; m_lo = 0; m_err = 0;
    for (int n = 0; n < 3000; n++) begin
      logic act;
      logic [31:0] exp_rd;
      ex_valid  = ($urandom_range(0, 9) < 7);
      ex_op     = 3'($urandom_range(0, 7));
      ex_flush  = ($urandom_range(0, 9) == 0);
      ex_rs_val = $urandom;
      ex_rt_val = ($urandom_range(0, 15) == 0) ? 32'd0 : $urandom;
      md_ack    = pend && (k == a_cyc);
      md_done   = pend && ((k == c_cyc) || (k <= a_cyc && $urandom_range(0, 3) == 0));
      md_hi     = (pend && k == c_cyc) ? p_res[63:32] : $urandom;
      md_lo     = (pend && k == c_cyc) ? p_res[31:0]  : $urandom;
      act = ex_valid & ~ex_flush;
      exp_rd = 0;
      if (!pend && act && ex_op == OP_MFHI) exp_rd = m_hi;
      if (!pend && act && ex_op == OP_MFLO) exp_rd = m_lo;
      @(negedge clk);
      check("rnd_stall", ex_stall, act & pend);
      check("rnd_req", md_req, pend && (k <= a_cyc));
      check("rnd_rdata", ex_rdata, exp_rd);
      check("rnd_err", md_err, m_err);
      if (pend) begin
        check("rnd_md_a", md_a, p_a);
        check("rnd_md_b", md_b, p_b);
        check("rnd_md_op", md_op, p_op);
      end
      tick();
      if (pend) begin
        if (k == c_cyc) begin
          m_hi = p_res[63:32]; m_lo = p_res[31:0]; pend = 0;
          $display("rnd op=%0d a=0x%08h b=0x%08h done at cycle %0d hi=0x%08h lo=0x%08h", p_op, p_a, p_b, k, m_hi, m_lo);
        end else if (k == 64) begin
          pend = 0; m_err = 1;
          $display("rnd op=%0d a=0x%08h b=0x%08h timed out", p_op, p_a, p_b);
        end else begin
          k++;
        end
      end else if (act) begin
        if (ex_op < 4) begin
          int unsigned mode;
          pend = 1; k = 1;
          p_op = ex_op[1:0]; p_a = ex_rs_val; p_b = ex_rt_val;
          p_res = engine_result(p_op, p_a, p_b);
          mode = $urandom_range(0, 7);
          a_cyc = (mode == 0) ? 70 : int'($urandom_range(1, 6));
          c_cyc = (mode == 1) ? 1000 : (mode == 2) ? 64 : a_cyc + 1 + int'($urandom_range(0, 8));
        end else if (ex_op == OP_MTHI) begin
          m_hi = ex_rs_val;
        end else if (ex_op == OP_MTLO) begin
          m_lo = ex_rs_val;
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/hilo_ctrl.md
Name: hilo_ctrl

Overview:
- EX-stage owner of the architectural HI/LO registers and initiator side of the multiply/divide engine request interface.
- Decodes MULT/MULTU/DIV/DIVU and issues them to the engine over a req/ack/done handshake, then writes the returned hi/lo into HI/LO.
- Serves MFHI/MFLO/MTHI/MTLO and raises the EX stall whenever HI/LO are not yet valid.
- The engine is non-blocking: the issuing instruction leaves EX immediately, and later HI/LO users interlock.

Parameters:
- WAIT_LIMIT, 64: maximum cycles spent in REQ+WAIT before the request is abandoned and md_err is set.
- CNT_W, 7: width of the wait counter; must satisfy 2^CNT_W > WAIT_LIMIT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- ex_valid  in  1  EX holds a valid HI/LO-class instruction.
- ex_op  in  3  decoded op: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MFHI, 5 MFLO, 6 MTHI, 7 MTLO.
- ex_flush  in  1  kill the EX instruction this cycle.
- ex_rs_val  in  32  rs operand; also the source for MTHI/MTLO.
- ex_rt_val  in  32  rt operand.
- ex_stall  out  1  hold EX (and upstream stages) this cycle.
- ex_rdata  out  32  MFHI/MFLO result.
- md_req  out  1  request valid to the engine.
- md_op  out  2  engine op: 00 mult, 01 multu, 10 div, 11 divu.
- md_a  out  32  operand A, registered.
- md_b  out  32  operand B, registered.
- md_ack  in  1  engine accepted the request.
- md_done  in  1  single-cycle pulse: result valid.
- md_hi  in  32  result high word (remainder for div).
- md_lo  in  32  result low word (quotient for div).
- md_err  out  1  sticky timeout flag.

Behaviour:
- Reset (asynchronous, rst_n=0) clears:
  - state to IDLE; HI, LO, md_a, md_b, md_op and the wait counter to 0.
  - md_req=0, md_err=0, ex_stall=0, ex_rdata=0.
- Definitions:
  - act = ex_valid & ~ex_flush.
  - is_md = act & ex_op<4.
  - is_hl = act (any op 0..7).
  - busy = state!=IDLE.
- ex_stall = is_hl & busy, combinational. It is never asserted in IDLE.
- State IDLE:
  - is_md: latch md_a=ex_rs_val, md_b=ex_rt_val, md_op=ex_op[1:0]; clear the counter; go to REQ. The instruction is not stalled.
  - MTHI/MTLO: HI or LO <= ex_rs_val at this edge.
  - MFHI/MFLO: ex_rdata = HI or LO combinationally; ex_rdata=0 for any other op.
- State REQ:
  - md_req=1; md_a/md_b/md_op are held stable.
  - md_ack=1: go to WAIT, md_req drops the next cycle.
  - md_done is ignored in REQ.
- State WAIT:
  - md_done=1: HI<=md_hi and LO<=md_lo at this edge; go to IDLE.
  - A stalled HI/LO instruction proceeds the following cycle. There is no same-cycle bypass.
- Counter:
  - Increments every cycle in REQ or WAIT, saturating.
  - When the counter reaches WAIT_LIMIT-1 without md_done, the next edge goes to IDLE, drops md_req, sets md_err=1, and leaves HI/LO unchanged.
  - md_err is cleared only by reset.
- Simultaneous events:
  - md_done on the same edge as the timeout: done wins, HI/LO are written, md_err is not set.
- ex_flush:
  - Kills only the current EX instruction: no issue, no HI/LO write, no stall.
  - An operation already in REQ/WAIT always runs to completion or timeout.
- Reset mid-operation: immediate return to IDLE, md_req deasserts asynchronously, and any pending engine result is discarded.
- Division by zero and overflow: the engine's values are written unchanged; no checking here.

Decomposition:
- Shared package, hilo_pkg, holds:
  - op codes OP_MULT..OP_MTLO (3-bit);
  - engine codes MD_MULT, MD_MULTU, MD_DIV, MD_DIVU (2-bit);
  - state encoding IDLE/REQ/WAIT.
- One sub-module, hilo_regs: the HI/LO register pair with write-enable/select and read mux.
- The FSM, counter and stall logic stay in hilo_ctrl.

Test Plan:
- MULT rs=0xFFFFFFFE, rt=3; engine acks after 2 cycles, done after 5 with hi=0xFFFFFFFF, lo=0xFFFFFFFA.
  - Required: md_req high exactly until ack; HI=0xFFFFFFFF and LO=0xFFFFFFFA after done; no stall on the MULT itself.
- DIV issued, then MFLO next cycle, engine done 32 cycles later.
  - Required: ex_stall=1 through the done cycle, 0 the cycle after.
  - Required: ex_rdata equals the new LO.
- MTLO rs=0x12345678 in IDLE, then MFLO.
  - Required: ex_rdata=0x12345678 with no stall.
- DIVU with ex_flush=1 in the same cycle.
  - Required: md_req never asserts; HI/LO are unchanged.
- MULTU where the engine never sends done, WAIT_LIMIT=64.
  - Required: return to IDLE after 64 cycles, md_err=1, HI/LO unchanged, a subsequent MFHI is not stalled.
- Assert rst_n=0 while in WAIT.
  - Required: md_req=0 and state IDLE immediately; a late md_done is ignored; HI=LO=0.
